pio_host_ctrl: RTL
==================

# pio_host_ctrl

Host-side sequencer for one `pio` instance. After reset it streams a program image and a configuration list from two synchronous ROMs into the PIO command port. It then enters a run phase in which it shares the TX-push command path among up to four requesters, one per state machine, using round-robin arbitration gated by each machine's TX-FIFO-full flag. It replaces the ad-hoc top-level load/push state machines with one reusable controller.

## Interface

Parameters:
- `PROG_LEN`, default 32: number of program words loaded (1..32).
- `CONF_LEN`, default 5: number of configuration entries applied (1..32).
- `NREQ`, default 4: number of push requesters (1..4). Requester i always targets machine i.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `restart`  in  1  single-cycle pulse; re-runs the full load sequence. Sampled only in RUN.
- `prog_addr`  out  5  program ROM address.
- `prog_data`  in  16  program ROM data, valid one cycle after the address.
- `conf_addr`  out  5  configuration ROM address.
- `conf_data`  in  38  configuration ROM data, valid one cycle after the address. Fields: [37:36] mindex, [35:32] action, [31:0] din.
- `req_valid`  in  NREQ  push request, one bit per requester.
- `req_data`  in  32*NREQ  push data; requester i occupies bits [32i+31:32i].
- `req_ready`  out  NREQ  grant, one-hot or zero; a transfer occurs when valid & ready.
- `pio_action`  out  4  PIO command. 0 = none, 1 = write instruction, 4 = push. Other values only as given by the configuration ROM.
- `pio_din`  out  32  PIO command data.
- `pio_index`  out  5  instruction index for action 1.
- `pio_mindex`  out  2  target state machine.
- `pio_tx_full`  in  4  TX-FIFO-full flags from the PIO.
- `loaded`  out  1  high while in RUN.
- `stall_cnt`  out  8  saturating count of stalled request-cycles.

## Operation

- States: LOAD_PROG, then LOAD_CONF, then DRAIN, then RUN. Reset enters LOAD_PROG with the address counter at 0.
- All `pio_*` outputs are registered. In reset and in every idle cycle they are `pio_action`=0, `pio_din`=0, `pio_index`=0, `pio_mindex`=0. Reset values of the remaining outputs: `req_ready`=0, `loaded`=0, `stall_cnt`=0, `prog_addr`=0, `conf_addr`=0.
- LOAD_PROG:
  - Issues `prog_addr` k in cycle k, for k = 0..PROG_LEN-1.
  - In cycle k+2 it drives `pio_action`=1, `pio_index`=k, `pio_din`={16'h0, word k}, `pio_mindex`=0.
- LOAD_CONF:
  - Issues `conf_addr` j in cycle PROG_LEN+j, for j = 0..CONF_LEN-1.
  - In cycle PROG_LEN+j+2 it drives action, din and mindex from entry j, with `pio_index`=0.
  - An entry whose action field is 0 is a no-op cycle.
- DRAIN: waits for the final command to retire. In cycle PROG_LEN+CONF_LEN+2, `pio_action`=0 and `loaded` rises. RUN starts in that cycle.
- RUN arbitration:
  - Requester i is eligible when `req_valid[i]` is high, `pio_tx_full[i]` is low, and i was not granted in the previous cycle. The lockout covers the one-cycle lag of `tx_full`.
  - Round-robin: search starts at the index after the last grant (index 0 after reset or restart) and the first eligible index wins.
  - `req_ready` is combinational from eligibility and pointer, is asserted only in RUN, and is never asserted when `req_valid` is low.
  - A grant in cycle t produces `pio_action`=4, `pio_mindex`=i, `pio_din`=req_data[i] in cycle t+1, for exactly one cycle. With no grant the outputs are idle.
- `stall_cnt`: in RUN, add 1 in each cycle where any i has `req_valid[i]` & `pio_tx_full[i]`. Saturates at 255. Cleared only by reset.
- `restart` in RUN:
  - No grant is issued in that cycle; a push already granted in the previous cycle still appears.
  - Next cycle: LOAD_PROG with address 0, `loaded`=0, RR pointer reset.
  - `restart` in any other state is ignored.
- Reset mid-operation, including mid-load: all outputs take their reset values in the next cycle and the sequence restarts from program word 0.

## Timing

- First program command appears 2 cycles after reset deasserts.
- Full load latency: PROG_LEN+CONF_LEN+2 cycles from reset release to `loaded`=1. With defaults, `loaded` rises in cycle 39.
- Push latency: 1 cycle from grant to `pio_action`=4.
- Throughput:
  - One push per cycle overall.
  - At most one push per machine every 2 cycles.
  - With all 4 requesters continuously valid and no FIFO full, grants rotate 0,1,2,3,0,...

## Test plan

- Reset release, defaults, ROM words k = 16'h1000+k → `pio_action`=1 with `pio_index`=k and `pio_din`=32'h1000+k in cycles 2..33. Five config commands in cycles 34..38. `loaded`=1 in cycle 39.
- RUN, requesters 0..3 all valid, data 32'hA0..32'hA3, no FIFO full → pushes with mindex 0,1,2,3,0 on consecutive cycles and matching data. Each `req_ready` pulse is exactly one cycle wide.
- Only requester 2 valid continuously → action=4 with mindex 2 every second cycle. `req_ready[2]` alternates 1/0.
- `pio_tx_full[1]`=1 for 10 cycles while requesters 1 and 3 are valid → only machine 3 is pushed. `stall_cnt` increases by 10. Requester 1 is served at the first eligible cycle after full clears.
- 300 cycles with `pio_tx_full[0]`=1 and `req_valid[0]`=1 → `stall_cnt` = 255, with no wrap.
- `restart` pulse in RUN → `loaded`=0 next cycle and program word 0 is reissued. Separately, `reset` asserted during LOAD_CONF → idle outputs next cycle, then the full sequence reruns from program word 0.

Source files
------------

// File: rtl/pio_host_ctrl.sv
// Host sequencer for one PIO: loads program and config from ROMs,
// then round-robin arbitrates TX pushes from up to four requesters.
module pio_host_ctrl #(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 5,
  parameter int NREQ     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 restart,
  output logic [4:0]           prog_addr,
  input  logic [15:0]          prog_data,
  output logic [4:0]           conf_addr,
  input  logic [37:0]          conf_data,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic [3:0]           pio_action,
  output logic [31:0]          pio_din,
  output logic [4:0]           pio_index,
  output logic [1:0]           pio_mindex,
  input  logic [3:0]           pio_tx_full,
  output logic                 loaded,
  output logic [7:0]           stall_cnt
);

  localparam logic [4:0] P_LAST = 5'(PROG_LEN - 1);
  localparam logic [4:0] C_LAST = 5'(CONF_LEN - 1);

  typedef enum logic [1:0] {
    LOAD_PROG,
    LOAD_CONF,
    DRAIN,
    RUN
  } state_t;

  state_t          r_state, w_state_nx;
  logic [4:0]      r_cnt, w_cnt_nx;
  logic            w_ld_vld, w_ld_conf;
  logic            r_d1_vld, r_d1_conf;
  logic [4:0]      r_d1_idx;
  logic            w_run;
  logic [1:0]      r_ptr, w_ptr_nx;
  logic [NREQ-1:0] r_prev, w_elig, w_gnt, w_full;
  logic            w_hit, w_stall_hit;
  logic [1:0]      w_gidx;
  logic [31:0]     w_gdata;
  logic [3:0]      r_act, w_act;
  logic [4:0]      r_idx, w_idx;
  logic [31:0]     r_din, w_din;
  logic [1:0]      r_mdx, w_mdx;
  logic [7:0]      r_stall;

  assign w_run  = (r_state == RUN);
  assign w_full = pio_tx_full[NREQ-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= LOAD_PROG;
      r_cnt     <= '0;
      r_d1_vld  <= 1'b0;
      r_d1_conf <= 1'b0;
      r_d1_idx  <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_d1_vld  <= w_ld_vld;
      r_d1_conf <= w_ld_conf;
      r_d1_idx  <= r_cnt;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_ld_vld   = 1'b0;
    w_ld_conf  = 1'b0;
    unique case (r_state)
      LOAD_PROG: begin
        w_ld_vld = 1'b1;
        if (r_cnt == P_LAST) begin
          w_state_nx = LOAD_CONF;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 5'd1;
        end
      end
      LOAD_CONF: begin
        w_ld_vld  = 1'b1;
        w_ld_conf = 1'b1;
        if (r_cnt == C_LAST) begin
          w_state_nx = DRAIN;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 5'd1;
        end
      end
      DRAIN: begin
        if (r_cnt == 5'd1) begin
          w_state_nx = RUN;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 5'd1;
        end
      end
      RUN: begin
        if (restart) begin
          w_state_nx = LOAD_PROG;
          w_cnt_nx   = '0;
        end
      end
    endcase
  end

  // Lockout on r_prev hides the one-cycle lag of tx_full.
  always_comb begin
    w_elig = '0;
    if (w_run && !restart)
      w_elig = req_valid & ~w_full & ~r_prev;
    w_gnt  = '0;
    w_hit  = 1'b0;
    w_gidx = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!w_hit && w_elig[(int'(r_ptr) + o) % NREQ]) begin
        w_hit  = 1'b1;
        w_gidx = 2'((int'(r_ptr) + o) % NREQ);
        w_gnt[(int'(r_ptr) + o) % NREQ] = 1'b1;
      end
    end
    w_gdata = req_data[32*int'(w_gidx) +: 32];
  end

  always_comb begin
    w_ptr_nx = r_ptr;
    if (w_run && restart)
      w_ptr_nx = '0;
    else if (w_hit)
      w_ptr_nx = 2'((int'(w_gidx) + 1) % NREQ);
  end

  always_comb begin
    w_act = '0;
    w_idx = '0;
    w_din = '0;
    w_mdx = '0;
    unique case (1'b1)
      r_d1_vld && !r_d1_conf: begin
        w_act = 4'd1;
        w_idx = r_d1_idx;
        w_din = {16'h0, prog_data};
      end
      r_d1_vld && r_d1_conf && (conf_data[35:32] != 4'd0): begin
        w_act = conf_data[35:32];
        w_din = conf_data[31:0];
        w_mdx = conf_data[37:36];
      end
      w_hit: begin
        w_act = 4'd4;
        w_din = w_gdata;
        w_mdx = w_gidx;
      end
      default: ;
    endcase
  end

  assign w_stall_hit = w_run && |(req_valid & w_full);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_act   <= '0;
      r_idx   <= '0;
      r_din   <= '0;
      r_mdx   <= '0;
      r_ptr   <= '0;
      r_prev  <= '0;
      r_stall <= '0;
    end else begin
      r_act  <= w_act;
      r_idx  <= w_idx;
      r_din  <= w_din;
      r_mdx  <= w_mdx;
      r_ptr  <= w_ptr_nx;
      r_prev <= w_gnt;
      if (w_stall_hit && r_stall != 8'hFF)
        r_stall <= r_stall + 8'd1;
    end
  end

  assign prog_addr  = (r_state == LOAD_PROG) ? r_cnt : '0;
  assign conf_addr  = (r_state == LOAD_CONF) ? r_cnt : '0;
  assign req_ready  = w_gnt;
  assign loaded     = w_run;
  assign stall_cnt  = r_stall;
  assign pio_action = r_act;
  assign pio_index  = r_idx;
  assign pio_din    = r_din;
  assign pio_mindex = r_mdx;

endmodule
